// File: rtl/conn_lookup_requester.sv
// Lookup initiator for the connection manager: issues tagged key lookups, pairs in-order responses with their tags.
// Optional CONN_LOOKUP_STATS_EN adds saturating hit_count / miss_count outputs.
module conn_lookup_requester #(
    parameter int KEY_W           = 64,
    parameter int RESP_W          = 32,
    parameter int TAG_W           = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               s_req_valid,
    output logic                               s_req_ready,
    input  logic [KEY_W-1:0]                   s_req_key,
    input  logic [TAG_W-1:0]                   s_req_tag,
    output logic                               m_lookup_valid,
    input  logic                               m_lookup_ready,
    output logic [KEY_W-1:0]                   m_lookup_key,
    input  logic                               s_lookup_valid,
    output logic                               s_lookup_ready,
    input  logic                               s_lookup_hit,
    input  logic [RESP_W-1:0]                  s_lookup_resp,
    output logic                               m_res_valid,
    input  logic                               m_res_ready,
    output logic [TAG_W-1:0]                   m_res_tag,
    output logic                               m_res_hit,
    output logic [RESP_W-1:0]                  m_res_resp,
`ifdef CONN_LOOKUP_STATS_EN
    output logic [31:0]                        hit_count,
    output logic [31:0]                        miss_count,
`endif
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               err_orphan
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic               req_valid;
    logic [KEY_W-1:0]   req_key;
    logic [TAG_W-1:0]   req_tag;

    logic [TAG_W-1:0]   tag_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_count;

    logic               res_valid;
    logic               req_fire;
    logic               issue_fire;
    logic               rsp_fire;
    logic               fifo_empty;
    logic               pop;
    logic               orphan;

    assign fifo_empty = (fifo_count == '0);
    assign req_fire   = s_req_valid && s_req_ready;
    assign issue_fire = req_valid && m_lookup_ready;
    assign rsp_fire   = s_lookup_valid && s_lookup_ready;
    assign pop        = rsp_fire && !fifo_empty;
    assign orphan     = rsp_fire && fifo_empty;

    // Conservative bound: a pop in the same cycle does not free a slot, so the FIFO can never overflow.
    assign s_req_ready    = (!req_valid || m_lookup_ready) && (outstanding < MAX_CNT);
    assign s_lookup_ready = !res_valid || m_res_ready || fifo_empty;

    assign m_lookup_valid = req_valid;
    assign m_lookup_key   = req_key;
    assign m_res_valid    = res_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_valid <= 1'b0;
            req_key   <= '0;
            req_tag   <= '0;
        end else if (req_fire) begin
            req_valid <= 1'b1;
            req_key   <= s_req_key;
            req_tag   <= s_req_tag;
        end else if (issue_fire) begin
            req_valid <= 1'b0;
        end
    end

    // NOTE: the tag storage has no reset; only pointers and count define validity, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (issue_fire) tag_mem[wr_ptr] <= req_tag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (issue_fire) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)        rd_ptr <= rd_ptr + PTR_ONE;
            case ({issue_fire, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Registered copy of fifo_count + req_valid, kept so the output is glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({req_fire, pop})
                2'b10:   outstanding <= outstanding + CNT_ONE;
                2'b01:   outstanding <= outstanding - CNT_ONE;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid  <= 1'b0;
            m_res_tag  <= '0;
            m_res_hit  <= 1'b0;
            m_res_resp <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (pop) begin
                res_valid  <= 1'b1;
                m_res_tag  <= tag_mem[rd_ptr];
                m_res_hit  <= s_lookup_hit;
                m_res_resp <= s_lookup_resp;
            end else if (m_res_ready) begin
                res_valid  <= 1'b0;
            end
            if (orphan) err_orphan <= 1'b1;
        end
    end

`ifdef CONN_LOOKUP_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (res_valid && m_res_ready) begin
            if (m_res_hit) begin
                if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            end else begin
                if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_conn_lookup_requester.sv
// Scoreboard bench for conn_lookup_requester: a manager model answers lookups in order, a monitor checks results.
// Build with CONN_LOOKUP_STATS_EN to also exercise the hit/miss counters.
module tb_conn_lookup_requester;

    typedef struct packed {
        logic [7:0]  tag;
        logic        hit;
        logic [31:0] resp;
    } res_t;

    typedef struct packed {
        logic [63:0] key;
        logic [7:0]  tag;
        logic        hit;
        logic [31:0] resp;
    } vec_t;

    typedef struct {
        logic [63:0] key;
        int          t;
    } iss_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_req_valid, s_req_ready;
    logic [63:0] s_req_key;
    logic [7:0]  s_req_tag;
    logic        m_lookup_valid, m_lookup_ready;
    logic [63:0] m_lookup_key;
    logic        s_lookup_valid, s_lookup_ready, s_lookup_hit;
    logic [31:0] s_lookup_resp;
    logic        m_res_valid, m_res_ready;
    logic [7:0]  m_res_tag;
    logic        m_res_hit;
    logic [31:0] m_res_resp;
    logic [2:0]  outstanding;
    logic        err_orphan;
`ifdef CONN_LOOKUP_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    conn_lookup_requester #(
        .KEY_W(64), .RESP_W(32), .TAG_W(8), .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk), .rst(rst),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_req_key(s_req_key), .s_req_tag(s_req_tag),
        .m_lookup_valid(m_lookup_valid), .m_lookup_ready(m_lookup_ready),
        .m_lookup_key(m_lookup_key),
        .s_lookup_valid(s_lookup_valid), .s_lookup_ready(s_lookup_ready),
        .s_lookup_hit(s_lookup_hit), .s_lookup_resp(s_lookup_resp),
        .m_res_valid(m_res_valid), .m_res_ready(m_res_ready),
        .m_res_tag(m_res_tag), .m_res_hit(m_res_hit), .m_res_resp(m_res_resp),
`ifdef CONN_LOOKUP_STATS_EN
        .hit_count(hit_count), .miss_count(miss_count),
`endif
        .outstanding(outstanding), .err_orphan(err_orphan)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_issued = 0;
    bit   mgr_en;
    int   mgr_lat;
    int   inject_req = 0;
    int   inject_done = 0;
    res_t exp_q[$];
    logic [63:0] key_q[$];
    iss_t mgr_q[$];

    // Hand-computed vectors; the manager answers hit = ~key[0], resp = {16'hDEAD, key[31:16]}.
    vec_t t1_v = '{64'h0000_0A00_0001_1F90, 8'h05, 1'b1, 32'hDEAD_0001};
    vec_t fill_v[6] = '{
        '{64'h0000_0000_1111_0000, 8'h00, 1'b1, 32'hDEAD_1111},
        '{64'h0000_0000_2222_0001, 8'h01, 1'b0, 32'hDEAD_2222},
        '{64'h0000_0000_3333_0002, 8'h02, 1'b1, 32'hDEAD_3333},
        '{64'h0000_0000_4444_0003, 8'h03, 1'b0, 32'hDEAD_4444},
        '{64'h0000_0000_5555_0004, 8'h04, 1'b1, 32'hDEAD_5555},
        '{64'h0000_0000_6666_0005, 8'h05, 1'b0, 32'hDEAD_6666}};
    vec_t stall_v[2] = '{
        '{64'hAAAA_0000_7777_0006, 8'h10, 1'b1, 32'hDEAD_7777},
        '{64'hBBBB_0000_8888_0007, 8'h11, 1'b0, 32'hDEAD_8888}};
    vec_t lk_v = '{64'h1234_5678_9ABC_DEF0, 8'h20, 1'b1, 32'hDEAD_9ABC};
    vec_t rst_v[3] = '{
        '{64'h0000_0000_0F0F_0008, 8'h30, 1'b1, 32'hDEAD_0F0F},
        '{64'h0000_0000_0E0E_0009, 8'h31, 1'b0, 32'hDEAD_0E0E},
        '{64'h0000_0000_0D0D_000A, 8'h32, 1'b1, 32'hDEAD_0D0D}};
    vec_t stat_v[6] = '{
        '{64'h0000_0000_0101_0010, 8'h40, 1'b1, 32'hDEAD_0101},
        '{64'h0000_0000_0202_0011, 8'h41, 1'b0, 32'hDEAD_0202},
        '{64'h0000_0000_0303_0012, 8'h42, 1'b1, 32'hDEAD_0303},
        '{64'h0000_0000_0404_0013, 8'h43, 1'b0, 32'hDEAD_0404},
        '{64'h0000_0000_0505_0014, 8'h44, 1'b1, 32'hDEAD_0505},
        '{64'h0000_0000_0606_0016, 8'h45, 1'b1, 32'hDEAD_0606}};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait expired, condition never observed", name);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Manager model: records issued lookups, answers them in order after mgr_lat cycles.
    initial begin
        logic fire;
        iss_t e;
        s_lookup_valid = 1'b0;
        s_lookup_hit   = 1'b0;
        s_lookup_resp  = '0;
        forever begin
            @(negedge clk);
            if (m_lookup_valid && m_lookup_ready) begin
                n_issued++;
                if (key_q.size() == 0) timeout("lookup_unexpected");
                else check("lookup_key", m_lookup_key, key_q.pop_front());
                mgr_q.push_back('{m_lookup_key, cyc});
            end
            fire = s_lookup_valid && s_lookup_ready;
            @(posedge clk);
            #1;
            if (rst) begin
                s_lookup_valid = 1'b0;
            end else begin
                if (fire) s_lookup_valid = 1'b0;
                if (!s_lookup_valid) begin
                    if (inject_req != inject_done) begin
                        s_lookup_valid = 1'b1;
                        s_lookup_hit   = 1'b1;
                        s_lookup_resp  = 32'hBAD0_0000;
                        inject_done++;
                    end else if (mgr_en && mgr_q.size() > 0 && cyc >= mgr_q[0].t + mgr_lat) begin
                        e = mgr_q.pop_front();
                        s_lookup_valid = 1'b1;
                        s_lookup_hit   = ~e.key[0];
                        s_lookup_resp  = {16'hDEAD, e.key[31:16]};
                    end
                end
            end
        end
    end

    // Result monitor: every downstream handshake is compared against the scoreboard head.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (!rst && m_res_valid && m_res_ready) begin
                if (exp_q.size() == 0) timeout("res_unexpected");
                else begin
                    e = exp_q.pop_front();
                    check("res", {m_res_tag, m_res_hit, m_res_resp}, e);
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Call in the posedge+1 region; returns in the posedge+1 region after the handshake.
    task automatic send(input vec_t v);
        int n = 0;
        s_req_valid = 1'b1;
        s_req_key   = v.key;
        s_req_tag   = v.tag;
        @(negedge clk);
        while (!s_req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (s_req_ready) begin
            exp_q.push_back('{v.tag, v.hit, v.resp});
            key_q.push_back(v.key);
        end else begin
            timeout("send");
        end
        @(posedge clk);
        #1;
        s_req_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || m_res_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic orphan_probe(input string name);
        int n = 0;
        inject_req++;
        @(negedge clk);
        while (!s_lookup_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_lookup_valid) timeout(name);
        else begin
            check({name, "_ready"}, s_lookup_ready, 1);
            @(negedge clk);
            check({name, "_err"}, err_orphan, 1);
            check({name, "_res_valid"}, m_res_valid, 0);
        end
    endtask

    initial begin
        int n;
        int base;
        rst            = 1'b1;
        s_req_valid    = 1'b0;
        s_req_key      = '0;
        s_req_tag      = '0;
        m_lookup_ready = 1'b1;
        m_res_ready    = 1'b1;
        mgr_en         = 1'b1;
        mgr_lat        = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_lookup_valid", m_lookup_valid, 0);
        check("rst_res_valid", m_res_valid, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_err", err_orphan, 0);
        check("rst_res_data", {m_res_tag, m_res_hit, m_res_resp}, 0);
        rst = 1'b0;

        // Single lookup with a three-cycle manager round trip.
        mgr_lat = 3;
        sync();
        send(t1_v);
        @(negedge clk);
        check("t1_lookup_latency", m_lookup_valid, 1);
        n = 0;
        while (!(s_lookup_valid && s_lookup_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!(s_lookup_valid && s_lookup_ready)) timeout("t1_resp");
        else begin
            @(negedge clk);
            check("t1_res_latency", m_res_valid, 1);
        end
        wait_drain("t1_drain");
        check("t1_outstanding", outstanding, 0);

        // Back-to-back fill with responses withheld.
        mgr_en  = 1'b0;
        mgr_lat = 1;
        base    = n_issued;
        sync();
        fork
            begin
                for (int i = 0; i < 6; i++) send(fill_v[i]);
            end
        join_none
        repeat (10) @(negedge clk);
        check("fill_issued", n_issued - base, 4);
        check("fill_outstanding", outstanding, 4);
        check("fill_req_ready", s_req_ready, 0);
        mgr_en = 1'b1;
        wait_drain("fill_drain");
        check("fill_issued_all", n_issued - base, 6);

        // Downstream stall with two responses pending.
        sync();
        m_res_ready = 1'b0;
        send(stall_v[0]);
        send(stall_v[1]);
        n = 0;
        @(negedge clk);
        while (!m_res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("stall_lookup_ready", s_lookup_ready, 0);
        check("stall_resp_held", s_lookup_valid, 1);
        check("stall_res_valid", m_res_valid, 1);
        check("stall_res_tag", m_res_tag, 8'h10);
        check("stall_outstanding", outstanding, 1);
        @(negedge clk);
        check("stall_res_stable", {m_res_tag, m_res_hit, m_res_resp}, {8'h10, 1'b1, 32'hDEAD_7777});
        sync();
        m_res_ready = 1'b1;
        wait_drain("stall_drain");

        // Manager not ready: request register holds its key and blocks new requests.
        sync();
        m_lookup_ready = 1'b0;
        send(lk_v);
        @(negedge clk);
        check("lk_valid", m_lookup_valid, 1);
        check("lk_req_ready", s_req_ready, 0);
        repeat (2) @(negedge clk);
        check("lk_key_held", m_lookup_key, 64'h1234_5678_9ABC_DEF0);
        sync();
        m_lookup_ready = 1'b1;
        wait_drain("lk_drain");

        // Orphan response with an empty FIFO.
        orphan_probe("orphan");
        repeat (3) @(negedge clk);
        check("orphan_sticky", err_orphan, 1);

        // Asynchronous reset with three lookups outstanding.
        mgr_en = 1'b0;
        sync();
        for (int i = 0; i < 3; i++) send(rst_v[i]);
        repeat (3) @(negedge clk);
        check("pre_rst_outstanding", outstanding, 3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_lookup_valid", m_lookup_valid, 0);
        check("arst_res_valid", m_res_valid, 0);
        check("arst_outstanding", outstanding, 0);
        check("arst_err", err_orphan, 0);
        exp_q.delete();
        key_q.delete();
        mgr_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mgr_en = 1'b1;
        orphan_probe("late_resp");

        // Mixed hits and misses after reset.
        sync();
        for (int i = 0; i < 5; i++) send(stat_v[i]);
        wait_drain("stat_drain");
`ifdef CONN_LOOKUP_STATS_EN
        check("hit_count", hit_count, 3);
        check("miss_count", miss_count, 2);
        force dut.hit_count = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.hit_count;
        sync();
        send(stat_v[5]);
        wait_drain("sat_drain");
        check("hit_count_sat", hit_count, 32'hFFFF_FFFF);
        check("miss_count_after_sat", miss_count, 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
